bcd_serial_adder: RTL and testbench

- Digit-serial N-digit packed-BCD add/subtract unit for the ALU datapath.
- Directly upstream of the BCD result path: it steps operand digit pairs through a 4-bit binary add with carry-in, one digit per clock, then applies decimal (+6) correction.
- Carry is registered between digits. Results are presented through a start/done handshake.

---
 rtl/bcd_serial_adder_if.sv | 33 +++
 rtl/bcd_serial_adder.sv | 128 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_adder_if.sv
// Handshake and data bundle for the digit-serial BCD add/subtract unit.
//   start   : request, taken only while the unit is not busy
//   sub     : 0 = A+B, 1 = A-B (ten's complement), latched with start
//   A, B    : packed-BCD operands, digit 0 in bits [3:0]
//   busy    : a digit sequence is in progress
//   done    : one-cycle pulse, S/Cout/invalid just updated
//   S       : packed-BCD result, held until the next completion
//   Cout    : decimal carry out (for sub: 1 = no borrow)
//   invalid : an operand digit above 9 was latched for this result
// The master modport is the requester; the slave modport is the adder.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   S;
  logic                  Cout;
  logic                  invalid;

  modport master (
    output start, sub, A, B,
    input  busy, done, S, Cout, invalid
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, S, Cout, invalid
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD add/subtract unit. One operand digit pair is
// summed per clock with a registered carry, then decimal-corrected (+6).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_serial_adder_if (start/sub/A/B in,
//           busy/done/S/Cout/invalid out)
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_serial_adder_if.slave   bus
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [W-1:0]       a_reg, b_reg, res_reg, res_next;
  logic [IDX_W-1:0]   idx_reg;
  logic               sub_reg, carry_reg, inv_pend_reg;
  logic [W-1:0]       s_reg;
  logic               cout_reg, invalid_reg;

  logic               accept, last_digit;
  logic [3:0]         a_dig, b_dig, b_adj, digit;
  logic [4:0]         raw;
  logic               carry_next;
  logic [2*DIGITS-1:0] bad_digit;
  logic               any_bad;

  // Flag every operand digit that is not a legal BCD value.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit_check
      assign bad_digit[2*gi]   = (bus.A[4*gi +: 4] > 4'd9);
      assign bad_digit[2*gi+1] = (bus.B[4*gi +: 4] > 4'd9);
    end
  endgenerate
  assign any_bad = |bad_digit;

  // A new request is taken in IDLE and in the DONE cycle.
  assign accept     = bus.start && (state_reg != RUN);
  assign last_digit = (idx_reg == LAST_IDX);

  // One digit of the add: nines' complement of B for subtract, with the
  // initial carry of 1 supplying the extra +1 of the ten's complement.
  always_comb begin
    a_dig = a_reg[3:0];
    b_dig = b_reg[3:0];
    b_adj = sub_reg ? (4'd9 - b_dig) : b_dig;
    raw   = {1'b0, a_dig} + {1'b0, b_adj} + {4'b0000, carry_reg};
    if (raw > 5'd9) begin
      digit      = raw[3:0] + 4'd6;
      carry_next = 1'b1;
    end else begin
      digit      = raw[3:0];
      carry_next = 1'b0;
    end
  end

  // Result digits enter at the top and move down, so after DIGITS steps
  // digit 0 sits in bits [3:0].
  generate
    if (DIGITS == 1) begin : g_res_one
      assign res_next = digit;
    end else begin : g_res_many
      assign res_next = {digit, res_reg[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      res_reg      <= '0;
      idx_reg      <= '0;
      sub_reg      <= 1'b0;
      carry_reg    <= 1'b0;
      inv_pend_reg <= 1'b0;
      s_reg        <= '0;
      cout_reg     <= 1'b0;
      invalid_reg  <= 1'b0;
    end else if (accept) begin
      a_reg        <= bus.A;
      b_reg        <= bus.B;
      sub_reg      <= bus.sub;
      idx_reg      <= '0;
      carry_reg    <= bus.sub;
      inv_pend_reg <= any_bad;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> 4;
      b_reg     <= b_reg >> 4;
      res_reg   <= res_next;
      carry_reg <= carry_next;
      idx_reg   <= idx_reg + IDX_W'(1);
      if (last_digit) begin
        s_reg       <= res_next;
        cout_reg    <= carry_next;
        invalid_reg <= inv_pend_reg;
      end
    end
  end

  assign bus.busy    = (state_reg == RUN);
  assign bus.done    = (state_reg == DONE);
  assign bus.S       = s_reg;
  assign bus.Cout    = cout_reg;
  assign bus.invalid = invalid_reg;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): table-driven vectors,
// hand-written multi-cycle sequences and a scoreboard queue of expectations.
module tb_bcd_serial_adder;
  localparam int DIGITS = 4;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        inv;
  } vec_t;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        inv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();
  bcd_serial_adder #(.DIGITS(DIGITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb_q[$];
  exp_t cur_exp;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_count = 0;
  int   accept_count = 0;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Predict an accept shortly before the edge that will take it.
  always @(negedge clk) begin
    #3;
    if (rst_n && bus.start === 1'b1 && bus.busy === 1'b0) begin
      sb_q.push_back(cur_exp);
      accept_count++;
    end
  end

  // Compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done === 1'b1) begin
      done_count++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        $display("txn S=%h Cout=%b invalid=%b (exp %h %b %b)",
                 bus.S, bus.Cout, bus.invalid, e.s, e.c, e.inv);
        check("S", 32'(bus.S), 32'(e.s));
        check("Cout", 32'(bus.Cout), 32'(e.c));
        check("invalid", 32'(bus.invalid), 32'(e.inv));
      end
    end
  end

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Called at negedge+1; returns at negedge+1 of the DONE cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] es, input logic ec, input logic ei);
    int t = 0;
    while (bus.busy === 1'b1 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (bus.busy !== 1'b0) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout actual=busy required=idle at %0t", $time);
    end
    bus.A = a; bus.B = b; bus.sub = s;
    cur_exp = '{s: es, c: ec, inv: ei};
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    t = 0;
    while (sb_q.size() != 0 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout actual=no_done required=done at %0t", $time);
      sb_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, a0;
    int av, bv, r;
    logic sb;
    logic [15:0] es;
    logic ec;

    tbl[0]  = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    tbl[1]  = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0};
    tbl[3]  = '{16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0};
    tbl[4]  = '{16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0};
    tbl[5]  = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
    tbl[6]  = '{16'h000F, 16'h0000, 1'b0, 16'h0015, 1'b0, 1'b1};
    tbl[7]  = '{16'h0000, 16'h00B0, 1'b1, 16'h0050, 1'b1, 1'b1};
    tbl[8]  = '{16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[9]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[10] = '{16'h4321, 16'h4321, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[11] = '{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};

    bus.start = 1'b0; bus.sub = 1'b0; bus.A = '0; bus.B = '0;
    cur_exp = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_S", 32'(bus.S), 32'h0);
    check("rst_Cout", 32'(bus.Cout), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_invalid", 32'(bus.invalid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Latency: busy for 4 cycles after the accept edge, then one done cycle.
    bus.A = 16'h1234; bus.B = 16'h5678; bus.sub = 1'b0;
    cur_exp = '{s: 16'h6912, c: 1'b0, inv: 1'b0};
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      check("lat_busy", 32'(bus.busy), 32'h1);
      check("lat_done_low", 32'(bus.done), 32'h0);
    end
    @(negedge clk); #1;
    check("lat_done", 32'(bus.done), 32'h1);
    check("lat_busy_low", 32'(bus.busy), 32'h0);

    // Table vectors, back-to-back where the previous op ends in DONE.
    for (int i = 0; i < 12; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].s, tbl[i].c, tbl[i].inv);

    // Random valid operands checked against integer arithmetic.
    for (int i = 0; i < 12; i++) begin
      av = $urandom_range(0, 9999);
      bv = $urandom_range(0, 9999);
      sb = 1'($urandom_range(0, 1));
      if (sb) begin
        r = av - bv;
        ec = (r >= 0);
        if (r < 0) r = r + 10000;
      end else begin
        r = av + bv;
        ec = (r >= 10000);
        r = r % 10000;
      end
      es = int2bcd(r);
      run_op(int2bcd(av), int2bcd(bv), sb, es, ec, 1'b0);
    end

    // start held high: one accept every 5 cycles.
    d0 = done_count; a0 = accept_count;
    bus.A = 16'h0005; bus.B = 16'h0005; bus.sub = 1'b0;
    cur_exp = '{s: 16'h0010, c: 1'b0, inv: 1'b0};
    bus.start = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    bus.start = 1'b0;
    check("hold_accepts", 32'(accept_count - a0), 32'd3);
    check("hold_dones", 32'(done_count - d0), 32'd3);

    // Operands changed mid-RUN must not disturb the result.
    bus.A = 16'h0005; bus.B = 16'h0005; bus.sub = 1'b0;
    cur_exp = '{s: 16'h0010, c: 1'b0, inv: 1'b0};
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.A = 16'h9999; bus.B = 16'h9999; bus.sub = 1'b1;
    d0 = done_count;
    repeat (5) @(negedge clk);
    #1;
    check("midrun_done", 32'(done_count - d0), 32'd1);

    // Asynchronous reset mid-RUN.
    run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    bus.A = 16'h1111; bus.B = 16'h1111; bus.sub = 1'b0;
    cur_exp = '{s: 16'h2222, c: 1'b0, inv: 1'b0};
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_S", 32'(bus.S), 32'h0);
    check("arst_Cout", 32'(bus.Cout), 32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_done", 32'(bus.done), 32'h0);
    check("arst_invalid", 32'(bus.invalid), 32'h0);
    sb_q.delete();
    d0 = done_count;
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("arst_no_done", 32'(done_count - d0), 32'd0);
    run_op(16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0);

    check("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
